// File: rtl/dense_layer_param_pkg.sv
// Shared types and helpers for the parameterised dense layer.
// Holds the FSM state encoding plus saturate/ReLU on a wide signed carrier.
package dense_layer_param_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Wide enough for any accumulator + bias this block is built with.
    typedef logic signed [63:0] wide_t;

    // Clamp v into the signed range of a w-bit word.
    function automatic wide_t saturate(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t relu(input wide_t v);
        return (v < 0) ? wide_t'(0) : v;
    endfunction

endpackage

// File: rtl/dense_layer_param_if.sv
// Handshake and parameter-write bus of the dense layer.
// master: producer/consumer side; slave: the layer itself.
interface dense_layer_param_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int W     = 8
);
    localparam int NW = N_OUT * N_IN;
    localparam int WA = (NW > 1) ? $clog2(NW) : 1;
    localparam int BA = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic               w_we;
    logic [WA-1:0]      w_addr;
    logic [W-1:0]       w_data;
    logic               b_we;
    logic [BA-1:0]      b_addr;
    logic [W-1:0]       b_data;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic               out_valid;
    logic               out_ready;
    logic [N_OUT*W-1:0] out_data;

    modport master (
        output w_we, w_addr, w_data,
        output b_we, b_addr, b_data,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  w_we, w_addr, w_data,
        input  b_we, b_addr, b_data,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dense_layer_param_lane.sv
// One neuron: MAC accumulator, bias add, saturate and optional ReLU.
// Ports: clk/rst, clear/add/fin controls, x/wt/bias operands, y result.
module dense_lane
    import dense_layer_param_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int W    = 8,
    parameter int FRAC = 4,
    parameter int ACT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                add,
    input  logic                fin,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] wt,
    input  logic signed [W-1:0] bias,
    output logic signed [W-1:0] y
);
    localparam int AW = 2 * W + $clog2(N_IN);

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_sh;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  acc_base;
    logic signed [AW:0]    biased;
    wide_t                 act_v;

    assign prod    = (2*W)'(x) * (2*W)'(wt);
    assign prod_sh = prod >>> FRAC;
    // First beat of a sample starts from zero instead of the old sum.
    assign acc_base = clear ? '0 : acc;
    assign biased   = (AW+1)'(acc) + (AW+1)'(bias);

    always_comb begin
        act_v = saturate(64'(biased), W);
        if (ACT == 1) act_v = relu(act_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            y   <= '0;
        end else begin
            if (add) acc <= acc_base + AW'(prod_sh);
            if (fin) y <= W'(act_v);
        end
    end
endmodule

// File: rtl/dense_layer_param.sv
// Fully connected layer: streams N_IN elements, emits N_OUT packed results.
// Ports: clk, rst, bus (weight/bias writes, input stream, result handshake).
module dense_layer_param
    import dense_layer_param_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int W     = 8,
    parameter int FRAC  = 4,
    parameter int ACT   = 1
) (
    input logic                clk,
    input logic                rst,
    dense_layer_param_if.slave bus
);
    localparam int NW = N_OUT * N_IN;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] eidx;
    logic          accept;
    logic          first;
    logic          last;
    logic          fin;

    logic signed [W-1:0] w_mem [NW];
    logic signed [W-1:0] b_mem [N_OUT];

    assign bus.in_ready  = (state == IDLE) || (state == ACCUM);
    assign bus.out_valid = (state == OUTPUT);
    assign accept = bus.in_valid && bus.in_ready;
    assign first  = (state == IDLE);
    assign eidx   = first ? '0 : idx;
    assign last   = (eidx == IW'(N_IN - 1));
    assign fin    = (state == FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            state <= FINISH;
                            idx   <= '0;
                        end else begin
                            state <= ACCUM;
                            idx   <= eidx + IW'(1);
                        end
                    end
                end
                FINISH: state <= OUTPUT;
                OUTPUT: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Coefficient storage survives reset; only IDLE may update it.
    always_ff @(posedge clk) begin
        if (!rst && first) begin
            if (bus.w_we && int'(bus.w_addr) < NW)
                w_mem[bus.w_addr] <= bus.w_data;
            if (bus.b_we && int'(bus.b_addr) < N_OUT)
                b_mem[bus.b_addr] <= bus.b_data;
        end
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_lane
        logic signed [W-1:0] y;

        dense_lane #(
            .N_IN (N_IN),
            .W    (W),
            .FRAC (FRAC),
            .ACT  (ACT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clear (first),
            .add   (accept),
            .fin   (fin),
            .x     ($signed(bus.in_data)),
            .wt    (w_mem[o*N_IN + int'(eidx)]),
            .bias  (b_mem[o]),
            .y     (y)
        );

        assign bus.out_data[o*W +: W] = y;
    end
endmodule

// File: tb/tb_dense_layer_param.sv
// Directed bench for dense_layer_param (W=8, FRAC=4, N_IN=2, N_OUT=2).
// Runs an ACT=1 and an ACT=0 instance in lockstep on the same stimulus.
module tb_dense_layer_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dense_layer_param_if #(.N_IN(2), .N_OUT(2), .W(8)) bus_a ();
    dense_layer_param_if #(.N_IN(2), .N_OUT(2), .W(8)) bus_b ();

    assign bus_b.w_we      = bus_a.w_we;
    assign bus_b.w_addr    = bus_a.w_addr;
    assign bus_b.w_data    = bus_a.w_data;
    assign bus_b.b_we      = bus_a.b_we;
    assign bus_b.b_addr    = bus_a.b_addr;
    assign bus_b.b_data    = bus_a.b_data;
    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.out_ready = bus_a.out_ready;

    dense_layer_param #(
        .N_IN(2), .N_OUT(2), .W(8), .FRAC(4), .ACT(1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dense_layer_param #(
        .N_IN(2), .N_OUT(2), .W(8), .FRAC(4), .ACT(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] wv, input logic [7:0] bv);
        for (int i = 0; i < 4; i++) begin
            bus_a.w_we   = 1'b1;
            bus_a.w_addr = 2'(i);
            bus_a.w_data = wv;
            tick();
        end
        bus_a.w_we = 1'b0;
        for (int o = 0; o < 2; o++) begin
            bus_a.b_we   = 1'b1;
            bus_a.b_addr = 1'(o);
            bus_a.b_data = bv;
            tick();
        end
        bus_a.b_we = 1'b0;
    endtask

    // Feeds two beats, checks latency, compares both instances, releases.
    task automatic run(input string tag, input logic [7:0] x0,
                       input logic [7:0] x1, input logic [15:0] exp_a,
                       input logic [15:0] exp_b);
        check({tag, "_rdy0"}, 32'(bus_a.in_ready), 32'd1);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = x0;
        tick();
        check({tag, "_rdy1"}, 32'(bus_a.in_ready), 32'd1);
        bus_a.in_data = x1;
        tick();
        bus_a.in_valid = 1'b0;
        check({tag, "_ov_early"}, 32'(bus_a.out_valid), 32'd0);
        tick();
        check({tag, "_ov"}, 32'(bus_a.out_valid), 32'd1);
        check({tag, "_a"}, 32'(bus_a.out_data), 32'(exp_a));
        check({tag, "_b"}, 32'(bus_b.out_data), 32'(exp_b));
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        check({tag, "_idle"}, 32'(bus_a.out_valid), 32'd0);
    endtask

    initial begin
        bus_a.w_we      = 1'b0;
        bus_a.w_addr    = '0;
        bus_a.w_data    = '0;
        bus_a.b_we      = 1'b0;
        bus_a.b_addr    = '0;
        bus_a.b_data    = '0;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_ov", 32'(bus_a.out_valid), 32'd0);
        check("rst_od", 32'(bus_a.out_data), 32'd0);
        check("rst_rdy", 32'(bus_a.in_ready), 32'd1);

        load(8'h10, 8'h10);
        run("basic", 8'h10, 8'h20, 16'h4040, 16'h4040);

        // Consumer stalls: result and flags must hold.
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h10;
        tick();
        bus_a.in_data = 8'h20;
        tick();
        bus_a.in_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("hold_ov", 32'(bus_a.out_valid), 32'd1);
            check("hold_od", 32'(bus_a.out_data), 32'h4040);
            check("hold_rdy", 32'(bus_a.in_ready), 32'd0);
            tick();
        end
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        check("rel_ov", 32'(bus_a.out_valid), 32'd0);
        check("rel_rdy", 32'(bus_a.in_ready), 32'd1);

        // Reset mid-sample drops it; weights survive.
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h10;
        tick();
        bus_a.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("abort_ov", 32'(bus_a.out_valid), 32'd0);
            tick();
        end
        run("post_rst", 8'h10, 8'h20, 16'h4040, 16'h4040);

        load(8'hF0, 8'h00);
        run("neg", 8'h10, 8'h10, 16'h0000, 16'hE0E0);

        load(8'h70, 8'h10);
        run("sat_hi", 8'h70, 8'h70, 16'h7F7F, 16'h7F7F);

        load(8'h90, 8'hF0);
        run("sat_lo", 8'h70, 8'h70, 16'h0000, 16'h8080);

        // Write during ACCUM is dropped for this and later samples.
        load(8'h10, 8'h00);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h10;
        tick();
        bus_a.w_we   = 1'b1;
        bus_a.w_addr = 2'd1;
        bus_a.w_data = 8'h30;
        tick();
        bus_a.w_we     = 1'b0;
        bus_a.in_valid = 1'b0;
        tick();
        check("wlock_ov", 32'(bus_a.out_valid), 32'd1);
        check("wlock_od", 32'(bus_a.out_data), 32'h2020);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        run("wlock_next", 8'h10, 8'h10, 16'h2020, 16'h2020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
